remote_key_decoder: RTL and testbench
=====================================

# remote_key_decoder

Parametrised successor to the fixed 12-bit remote digit encoder. It takes complete SIRC frames from the IR receiver and filters them by device address. Held-key repeat frames are suppressed. Frames are then mapped to 4-bit calculator key codes: digits 0–9 and operators 0xA–0xF. Keys are queued in a small FIFO with a valid/ready handshake toward the calculator core.

## Interface
- CODE_W, 12, frame width (12, 15 or 20); command = bits [CODE_W-1:CODE_W-7], address = remaining low bits, both transmitted LSB-first (bit-reversed in field)
- DEV_ADDR, 1, accepted device address (CODE_W-7 bits, after bit-reversal)
- HOLD_CYCLES, 2_500_000, idle cycles after last frame before a held key counts as released (≥2)
- FIFO_DEPTH, 4, key queue depth (power of 2, ≥2)
- AUTO_N, 8, repeat frames before auto-repeat starts (only with REMOTE_AUTOREPEAT_EN)
- clk  in  1  sole clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- code_in  in  CODE_W  received frame
- code_valid  in  1  one-cycle strobe, code_in valid
- key_data  out  4  head-of-queue key code
- key_valid  out  1  queue non-empty
- key_ready  in  1  consumer accepts head when key_valid & key_ready
- key_err  out  1  one-cycle pulse: frame dropped (wrong address or unmapped command)
- overflow  out  1  sticky: key dropped because queue full; cleared only by clear

## Operation
- Command mapping (after bit-reversal): 0–8 → 0x1–0x9; 9 → 0x0; 0x10 → 0xA; 0x11 → 0xB; 0x12 → 0xC; 0x13 → 0xD; 0x0B → 0xE; 0x14 → 0xF.
- Any other command → key_err, no key.
- Address ≠ DEV_ADDR → key_err, no key. No state change.
- Repeat filter FSM, states IDLE and HELD; holds last_code and a timer.
  - IDLE + mapped frame → enqueue key, last_code ← code_in, timer ← 0, go to HELD.
  - HELD + frame == last_code → suppressed, timer ← 0.
  - HELD + frame ≠ last_code (mapped) → enqueue, last_code ← code_in, timer ← 0.
  - HELD, no frame, timer == HOLD_CYCLES-1 → IDLE. Otherwise timer increments.
  - Rejected frames (error) never touch the FSM or the timer.
- FIFO: push when a key is accepted; pop on key_valid & key_ready.
  - Full and no pop in the same cycle → key dropped, overflow set.
  - Full with a pop in the same cycle → push accepted.
  - Empty → no bypass; the key appears one cycle after the push.
- All reset values: FSM IDLE, timer 0, last_code 0, FIFO empty, key_data 0, key_valid 0, key_err 0, overflow 0.
- clear mid-operation discards the queue and any held state immediately.

## Timing
- code_valid sampled at edge N.
- Decode and filter registered at N+1; key_err pulses during cycle N+1.
- FIFO write at edge N+2; key_valid high after edge N+2 when the queue was empty (latency 2).
- Back-to-back code_valid every cycle is supported; each frame is evaluated in order.
- A frame arriving in the same cycle as the timeout wins. It is compared against last_code while still HELD, so a same-code frame is suppressed and the timer is reset.
- key_data is stable while key_valid & !key_ready.

## Configuration
- REMOTE_AUTOREPEAT_EN defined:
  - In HELD, a counter tracks consecutive suppressed same-code frames.
  - Once it reaches AUTO_N, every further same-code frame enqueues the key again.
  - The counter resets on a new code or on IDLE.
- REMOTE_AUTOREPEAT_EN undefined: a held key produces exactly one key per press, and the counter logic is absent.

## Test plan
- Reset, then frame 0x910 (digit 0, address 1) → key_err 0, key_valid rises 2 cycles later with key_data 0x0. Pop → key_valid 0.
- Frames 0x010, 0x810, 0x410 spaced 10 cycles apart, key_ready 0 → queue holds 1, 2, 3 in order. Then key_ready 1 → 0x1, 0x2, 0x3 on consecutive cycles.
- Frame 0x010 repeated 5 times, 20 cycles apart, with HOLD_CYCLES=50 → one key 0x1. Wait 60 idle cycles, send 0x010 → second 0x1.
- Frame 0x011 (address mismatch) and frame with command 0x30 → key_err pulse each, queue unchanged.
- FIFO_DEPTH=4, key_ready 0, six distinct keys → 4 queued, overflow 1 after the fifth. Assert clear mid-stream → all outputs 0 asynchronously.
- With REMOTE_AUTOREPEAT_EN, AUTO_N=3: held 0x810 for 6 frames → keys 0x2 (first frame), then 0x2 on frames 5 and 6.

Source files
------------

// File: rtl/remote_key_decoder.sv
// -----------------------------------------------------------------------------
// remote_key_decoder
//
// Turns complete SIRC frames from the IR receiver into 4-bit calculator key
// codes. Frames for another device or with an unknown command are dropped
// and flagged. Repeat frames sent while a key is held are suppressed. Accepted
// keys are queued in a small FIFO, which the calculator core drains through a
// valid/ready handshake.
//
// Pipeline:
//   edge N   : frame captured (code_valid_i sampled)
//   edge N+1 : decode + repeat filter registered; key_err_o high for one cycle
//   edge N+2 : key written into the FIFO; key_valid_o rises if it was empty
//
// Parameters:
//   CODE_W      frame width (12, 15 or 20)
//   DEV_ADDR    accepted device address (after bit reversal)
//   HOLD_CYCLES idle cycles after the last frame before a held key is released
//   FIFO_DEPTH  key queue depth (power of 2, >= 2)
//   AUTO_N      same-code repeat frames before auto-repeat starts
//               (present only when REMOTE_AUTOREPEAT_EN is defined)
//
// Optional feature macro: REMOTE_AUTOREPEAT_EN
//   Defined   : a key held long enough is re-enqueued on every further frame.
//   Undefined : one key per press; no repeat counter is built.
//
// Ports:
//   clk_i         in   1       sole clock, rising edge
//   clear_i       in   1       asynchronous active-high reset
//   code_i        in   CODE_W  received frame
//   code_valid_i  in   1       one-cycle strobe, code_i valid
//   key_data_o    out  4       head-of-queue key code (0 when queue empty)
//   key_valid_o   out  1       queue non-empty
//   key_ready_i   in   1       consumer takes head when key_valid_o & key_ready_i
//   key_err_o     out  1       one-cycle pulse: frame dropped (address/command)
//   overflow_o    out  1       sticky: key dropped because the queue was full
// -----------------------------------------------------------------------------
module remote_key_decoder #(
  parameter int CODE_W      = 12,
  parameter int DEV_ADDR    = 1,
  parameter int HOLD_CYCLES = 2_500_000,
  parameter int FIFO_DEPTH  = 4
`ifdef REMOTE_AUTOREPEAT_EN
  ,
  parameter int AUTO_N      = 8
`endif
) (
  input  logic              clk_i,
  input  logic              clear_i,
  input  logic [CODE_W-1:0] code_i,
  input  logic              code_valid_i,
  output logic [3:0]        key_data_o,
  output logic              key_valid_o,
  input  logic              key_ready_i,
  output logic              key_err_o,
  output logic              overflow_o
);

  localparam int CMD_W  = 7;
  localparam int ADDR_W = CODE_W - CMD_W;
  localparam int TMR_W  = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);

  localparam logic [TMR_W-1:0]  HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] MY_ADDR   = ADDR_W'(DEV_ADDR);
  localparam logic [AW:0]       FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // Stage 1: frame capture
  // ---------------------------------------------------------------------------
  logic              frame_vld_q;
  logic [CODE_W-1:0] frame_q;

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      frame_vld_q <= 1'b0;
      frame_q     <= '0;
    end else begin
      frame_vld_q <= code_valid_i;
      frame_q     <= code_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Field extraction. Both fields go over the air LSB first, so the bit that
  // lands in the top position of each field is the field's LSB.
  // ---------------------------------------------------------------------------
  logic [CMD_W-1:0]  cmd;
  logic [ADDR_W-1:0] addr;

  for (genvar gi = 0; gi < CMD_W; gi++) begin : g_cmd_rev
    assign cmd[gi] = frame_q[CODE_W-1-gi];
  end

  for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr_rev
    assign addr[gi] = frame_q[ADDR_W-1-gi];
  end

  // Command to key-code map
  logic       cmd_mapped;
  logic [3:0] cmd_key;

  always_comb begin
    cmd_mapped = 1'b1;
    cmd_key    = 4'h0;
    case (cmd)
      7'h00, 7'h01, 7'h02, 7'h03, 7'h04,
      7'h05, 7'h06, 7'h07, 7'h08: cmd_key = cmd[3:0] + 4'h1;
      7'h09:                      cmd_key = 4'h0;
      7'h10:                      cmd_key = 4'hA;
      7'h11:                      cmd_key = 4'hB;
      7'h12:                      cmd_key = 4'hC;
      7'h13:                      cmd_key = 4'hD;
      7'h0B:                      cmd_key = 4'hE;
      7'h14:                      cmd_key = 4'hF;
      default:                    cmd_mapped = 1'b0;
    endcase
  end

  logic frame_ok;
  assign frame_ok = frame_vld_q & cmd_mapped & (addr == MY_ADDR);

  // ---------------------------------------------------------------------------
  // Repeat filter FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CODE_W-1:0] last_code_q, last_code_d;
  logic              push_q, push_d;
  logic [3:0]        push_key_q, push_key_d;
  logic              key_err_q, key_err_d;

`ifdef REMOTE_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(AUTO_N + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(AUTO_N);
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    last_code_d = last_code_q;
    push_d      = 1'b0;
    push_key_d  = cmd_key;
    // A dropped frame only raises the error pulse; the filter below sees it
    // as an idle cycle.
    key_err_d   = frame_vld_q & ~frame_ok;
`ifdef REMOTE_AUTOREPEAT_EN
    rpt_cnt_d   = rpt_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (frame_ok) begin
          push_d      = 1'b1;
          last_code_d = frame_q;
          timer_d     = '0;
          state_d     = ST_HELD;
`ifdef REMOTE_AUTOREPEAT_EN
          rpt_cnt_d   = '0;
`endif
        end
      end

      ST_HELD: begin
        // A frame beats a coincident timeout: it is still compared while HELD.
        if (frame_ok) begin
          timer_d = '0;
          if (frame_q == last_code_q) begin
`ifdef REMOTE_AUTOREPEAT_EN
            if (rpt_cnt_q == RPT_LAST) begin
              push_d = 1'b1;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
`endif
          end else begin
            push_d      = 1'b1;
            last_code_d = frame_q;
`ifdef REMOTE_AUTOREPEAT_EN
            rpt_cnt_d   = '0;
`endif
          end
        end else if (timer_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          timer_d = '0;
`ifdef REMOTE_AUTOREPEAT_EN
          rpt_cnt_d = '0;
`endif
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      last_code_q <= '0;
      push_q      <= 1'b0;
      push_key_q  <= 4'h0;
      key_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      last_code_q <= last_code_d;
      push_q      <= push_d;
      push_key_q  <= push_key_d;
      key_err_q   <= key_err_d;
    end
  end

`ifdef REMOTE_AUTOREPEAT_EN
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      rpt_cnt_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
    end
  end
`endif

  assign key_err_o = key_err_q;

  // ---------------------------------------------------------------------------
  // Key FIFO
  // ---------------------------------------------------------------------------
  logic [3:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;

  logic fifo_full, fifo_empty, do_pop, do_push;

  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign do_pop     = ~fifo_empty & key_ready_i;
  // A pop frees the slot in the same cycle, so a full queue can still accept.
  assign do_push    = push_q & (~fifo_full | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_key_q;
    end
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_q & ~do_push) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Head is gated so the output reads 0 whenever the queue is empty,
  // including straight out of reset when the storage is uninitialised.
  assign key_valid_o = ~fifo_empty;
  assign key_data_o  = fifo_empty ? 4'h0 : mem_q[rd_ptr_q];
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_remote_key_decoder.sv
// -----------------------------------------------------------------------------
// Directed bench for remote_key_decoder (CODE_W=12, DEV_ADDR=1,
// HOLD_CYCLES=50, FIFO_DEPTH=4, AUTO_N=3 when REMOTE_AUTOREPEAT_EN is set).
// Outputs are sampled on the falling clock edge.
//
// Hand-computed frames (address 1 -> low field 5'b10000 = 0x10):
//   0x910 cmd 0x09 -> key 0x0    0x010 cmd 0x00 -> key 0x1
//   0x810 cmd 0x01 -> key 0x2    0x410 cmd 0x02 -> key 0x3
//   0xC10 cmd 0x03 -> key 0x4    0x210 cmd 0x04 -> key 0x5
//   0xA10 cmd 0x05 -> key 0x6    0x090 cmd 0x10 -> key 0xA
//   0xD10 cmd 0x0B -> key 0xE    0x0D0 cmd 0x30 -> unmapped
//   0x011 address 17             -> wrong device
// -----------------------------------------------------------------------------
module tb_remote_key_decoder;

  logic        clk;
  logic        clear;
  logic [11:0] code;
  logic        code_valid;
  logic [3:0]  key_data;
  logic        key_valid;
  logic        key_ready;
  logic        key_err;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  remote_key_decoder #(
    .CODE_W      (12),
    .DEV_ADDR    (1),
    .HOLD_CYCLES (50),
    .FIFO_DEPTH  (4)
`ifdef REMOTE_AUTOREPEAT_EN
    ,
    .AUTO_N      (3)
`endif
  ) dut (
    .clk_i        (clk),
    .clear_i      (clear),
    .code_i       (code),
    .code_valid_i (code_valid),
    .key_data_o   (key_data),
    .key_valid_o  (key_valid),
    .key_ready_i  (key_ready),
    .key_err_o    (key_err),
    .overflow_o   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Drives one frame for a single cycle; returns just after the sampling edge.
  task automatic send(input logic [11:0] c);
    @(negedge clk);
    code       = c;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Checks the head, then pops it on the next edge.
  task automatic pop_expect(input string tag, input logic [3:0] exp);
    check({tag, "_valid"}, 32'(key_valid), 32'd1);
    check({tag, "_data"},  32'(key_data),  32'(exp));
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    clear      = 1'b1;
    code       = '0;
    code_valid = 1'b0;
    key_ready  = 1'b0;
    #2;
    check("rst_valid",    32'(key_valid), 32'd0);
    check("rst_data",     32'(key_data),  32'd0);
    check("rst_err",      32'(key_err),   32'd0);
    check("rst_overflow", 32'(overflow),  32'd0);
    idle(2);
    clear = 1'b0;

    // Single key, latency 2
    send(12'h910);
    check("t1_err_n1",   32'(key_err),   32'd0);
    check("t1_valid_n1", 32'(key_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_n2", 32'(key_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_n3", 32'(key_valid), 32'd1);
    check("t1_data",     32'(key_data),  32'd0);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("t1_empty",    32'(key_valid), 32'd0);

    // Three spaced keys, drained on consecutive cycles
    send(12'h010); idle(9);
    send(12'h810); idle(9);
    send(12'h410); idle(3);
    check("t2_k1", 32'(key_data), 32'h1);
    key_ready = 1'b1;
    @(negedge clk); check("t2_k2", 32'(key_data), 32'h2);
    @(negedge clk); check("t2_k3", 32'(key_data), 32'h3);
    @(negedge clk); check("t2_empty", 32'(key_valid), 32'd0);
    key_ready = 1'b0;

    // Held key suppression, then release by timeout
    repeat (5) begin
      send(12'h010);
      idle(19);
    end
    pop_expect("t3_held", 4'h1);
    check("t3_one_only", 32'(key_valid), 32'd0);
    idle(60);
    send(12'h010);
    idle(2);
    pop_expect("t3_again", 4'h1);
    check("t3_empty", 32'(key_valid), 32'd0);

    // Rejected frames
    send(12'h011);
    @(negedge clk);
    check("t4_addr_err",   32'(key_err),   32'd1);
    @(negedge clk);
    check("t4_addr_pulse", 32'(key_err),   32'd0);
    check("t4_addr_noq",   32'(key_valid), 32'd0);
    send(12'h0D0);
    @(negedge clk);
    check("t4_cmd_err",    32'(key_err),   32'd1);
    @(negedge clk);
    check("t4_cmd_pulse",  32'(key_err),   32'd0);
    idle(2);
    check("t4_cmd_noq",    32'(key_valid), 32'd0);

    // Back-to-back operator frames
    @(negedge clk);
    code = 12'h090; code_valid = 1'b1;
    @(negedge clk);
    code = 12'hD10;
    @(negedge clk);
    code_valid = 1'b0;
    idle(2);
    pop_expect("t5_opA", 4'hA);
    pop_expect("t5_opE", 4'hE);
    check("t5_empty", 32'(key_valid), 32'd0);

    // Overflow, then asynchronous clear
    send(12'h010);
    send(12'h810);
    send(12'h410);
    send(12'hC10);
    idle(2);
    check("t6_ovf_full4", 32'(overflow), 32'd0);
    send(12'h210);
    idle(2);
    check("t6_ovf_set",   32'(overflow), 32'd1);
    check("t6_head",      32'(key_data), 32'h1);
    send(12'hA10);
    idle(2);
    check("t6_ovf_stick", 32'(overflow), 32'd1);
    @(negedge clk);
    #2 clear = 1'b1;
    #1;
    check("t6_clr_valid", 32'(key_valid), 32'd0);
    check("t6_clr_data",  32'(key_data),  32'd0);
    check("t6_clr_ovf",   32'(overflow),  32'd0);
    check("t6_clr_err",   32'(key_err),   32'd0);
    @(negedge clk);
    clear = 1'b0;

`ifdef REMOTE_AUTOREPEAT_EN
    // Auto-repeat: first frame, then frames 5 and 6
    repeat (6) begin
      send(12'h810);
      idle(19);
    end
    pop_expect("t7_first", 4'h2);
    pop_expect("t7_rpt5",  4'h2);
    pop_expect("t7_rpt6",  4'h2);
    check("t7_empty", 32'(key_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
